// File: rtl/melody_pkg.sv
// Shared definitions for the melody sequencer: table entry layout, special
// note codes, duration decoding and the playback FSM states.
package melody_pkg;

    localparam int ENTRY_W  = 11;
    localparam int DUR_MSB  = 10;
    localparam int DUR_LSB  = 9;
    localparam int OCT_MSB  = 8;
    localparam int OCT_LSB  = 5;
    localparam int NOTE_MSB = 4;
    localparam int NOTE_LSB = 1;
    localparam int RSVD_BIT = 0;

    localparam logic [3:0] NOTE_REST = 4'd12;
    localparam logic [3:0] NOTE_END  = 4'd15;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_PLAY,
        ST_GAP
    } state_t;

    // Duration code 0..3 selects 1, 2, 4 or 8 tick units.
    function automatic logic [3:0] dur_units(input logic [1:0] dur);
        return 4'd1 << dur;
    endfunction

    function automatic logic [ENTRY_W-1:0] melody_entry(
        input logic [1:0] dur,
        input logic [3:0] oct,
        input logic [3:0] note
    );
        return {dur, oct, note, 1'b0};
    endfunction

endpackage

// File: rtl/melody_rom.sv
// Melody table: synchronous-read lookup, one-cycle latency. Unlisted
// addresses hold the END marker so playback always terminates.
module melody_rom #(
    parameter int DEPTH_LOG2 = 6
) (
    input  logic                        clk,
    input  logic [DEPTH_LOG2-1:0]       addr,
    output logic [melody_pkg::ENTRY_W-1:0] data
);
    import melody_pkg::*;

    always_ff @(posedge clk) begin
        case (addr)
            DEPTH_LOG2'(0): data <= melody_entry(2'd0, 4'd5, 4'd6);
            DEPTH_LOG2'(1): data <= melody_entry(2'd1, 4'd4, NOTE_REST);
            DEPTH_LOG2'(2): data <= melody_entry(2'd0, 4'd5, 4'd2);
            default:        data <= melody_entry(2'd0, 4'd0, NOTE_END);
        endcase
    end

endmodule

// File: rtl/melody_sequencer.sv
// Autonomous melody player feeding the piano's one-hot key vector and octave,
// with per-note durations, a silent retrigger gap, start/stop and looping.
module melody_sequencer #(
    parameter int TICK_CYCLES = 187500,
    parameter int GAP_CYCLES  = 10000,
    parameter int DEPTH_LOG2  = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  loop,
    output logic [11:0]           keys,
    output logic [3:0]            octave,
    output logic                  busy,
    output logic                  note_strobe,
    output logic [DEPTH_LOG2-1:0] step_idx
);
    import melody_pkg::*;

    localparam int CNT_W = $clog2(8 * TICK_CYCLES);
    // PLAY exits when the counter reads 0 (load+1 cycles); GAP likewise, and
    // FETCH+DECODE are taken out of the gap so keys stay low GAP_CYCLES total.
    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYCLES - 3);

    state_t                  state_reg, state_next;
    logic [CNT_W-1:0]        cnt_reg, cnt_next;
    logic [DEPTH_LOG2-1:0]   step_idx_reg, step_idx_next;
    logic [11:0]             keys_reg, keys_next;
    logic [3:0]              octave_reg, octave_next;
    logic                    strobe_reg, strobe_next;

    logic [ENTRY_W-1:0]      rom_data;
    logic [1:0]              entry_dur;
    logic [3:0]              entry_oct;
    logic [3:0]              entry_note;
    logic [11:0]             key_dec;
    logic [CNT_W-1:0]        play_load;
    logic                    unused_rsvd;

    melody_rom #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_rom (
        .clk  (clk),
        .addr (step_idx_reg),
        .data (rom_data)
    );

    assign entry_dur   = rom_data[DUR_MSB:DUR_LSB];
    assign entry_oct   = rom_data[OCT_MSB:OCT_LSB];
    assign entry_note  = rom_data[NOTE_MSB:NOTE_LSB];
    assign unused_rsvd = rom_data[RSVD_BIT];

    // Bit 11 is note 0 (C) down to bit 0 for note 11 (B).
    generate
        for (genvar gi = 0; gi < 12; gi++) begin : g_key_dec
            assign key_dec[gi] = (entry_note == 4'(11 - gi));
        end
    endgenerate

    assign play_load = CNT_W'(32'(dur_units(entry_dur)) * 32'(TICK_CYCLES)
                              - 32'(GAP_CYCLES) - 32'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            cnt_reg      <= '0;
            step_idx_reg <= '0;
            keys_reg     <= '0;
            octave_reg   <= '0;
            strobe_reg   <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            step_idx_reg <= step_idx_next;
            keys_reg     <= keys_next;
            octave_reg   <= octave_next;
            strobe_reg   <= strobe_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        step_idx_next = step_idx_reg;
        keys_next     = keys_reg;
        octave_next   = octave_reg;
        strobe_next   = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next    = ST_FETCH;
                    step_idx_next = '0;
                end
            end
            ST_FETCH: begin
                state_next = ST_DECODE;
            end
            ST_DECODE: begin
                if (entry_note == NOTE_END) begin
                    step_idx_next = '0;
                    if (loop) begin
                        state_next = ST_FETCH;
                    end else begin
                        state_next  = ST_IDLE;
                        keys_next   = '0;
                        octave_next = '0;
                    end
                end else begin
                    state_next  = ST_PLAY;
                    strobe_next = 1'b1;
                    cnt_next    = play_load;
                    if (entry_note < NOTE_REST) begin
                        keys_next   = key_dec;
                        octave_next = entry_oct;
                    end else begin
                        keys_next = '0;
                    end
                end
            end
            ST_PLAY: begin
                if (cnt_reg == '0) begin
                    state_next = ST_GAP;
                    keys_next  = '0;
                    cnt_next   = GAP_LOAD;
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            ST_GAP: begin
                if (cnt_reg == '0) begin
                    state_next    = ST_FETCH;
                    step_idx_next = step_idx_reg + DEPTH_LOG2'(1);
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // Restart while playing abandons the current note silently.
        if (start && (state_reg != ST_IDLE)) begin
            state_next    = ST_FETCH;
            step_idx_next = '0;
            keys_next     = '0;
            cnt_next      = '0;
            strobe_next   = 1'b0;
        end

        if (stop) begin
            state_next    = ST_IDLE;
            step_idx_next = '0;
            keys_next     = '0;
            octave_next   = '0;
            cnt_next      = '0;
            strobe_next   = 1'b0;
        end
    end

    assign keys        = keys_reg;
    assign octave      = octave_reg;
    assign busy        = (state_reg != ST_IDLE);
    assign note_strobe = strobe_reg;
    assign step_idx    = step_idx_reg;

endmodule

// File: tb/tb_melody_sequencer.sv
// Scoreboard bench for melody_sequencer with a short tick (20) and gap (4):
// expected notes are queued by the stimulus and checked on each note_strobe.
module tb_melody_sequencer;

    typedef struct {
        logic [11:0] keys;
        logic [3:0]  octave;
        logic [5:0]  idx;
        int          interval;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        stop;
    logic        loop;
    logic [11:0] keys;
    logic [3:0]  octave;
    logic        busy;
    logic        note_strobe;
    logic [5:0]  step_idx;

    exp_t        sb[$];
    exp_t        mon_e;
    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          last_strobe = 0;
    int          nb;

    logic [11:0] keys_log [0:127];
    logic [3:0]  oct_log  [0:127];
    logic        busy_log [0:127];

    melody_sequencer #(
        .TICK_CYCLES(20),
        .GAP_CYCLES (4),
        .DEPTH_LOG2 (6)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .stop       (stop),
        .loop       (loop),
        .keys       (keys),
        .octave     (octave),
        .busy       (busy),
        .note_strobe(note_strobe),
        .step_idx   (step_idx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    task automatic push(input logic [11:0] k, input logic [3:0] o,
                        input logic [5:0] i, input int iv);
        exp_t e;
        e.keys = k;
        e.octave = o;
        e.idx = i;
        e.interval = iv;
        sb.push_back(e);
    endtask

    // Samples n cycles at the falling edge; any pulse requested before the
    // call is released after the first sampled cycle.
    task automatic record(input int n);
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            start = 1'b0;
            stop  = 1'b0;
            keys_log[k] = keys;
            oct_log[k]  = octave;
            busy_log[k] = busy;
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && note_strobe) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_strobe: got strobe at step %0d, expected none", step_idx);
            end else begin
                mon_e = sb.pop_front();
                check("strobe_keys", int'(keys), int'(mon_e.keys));
                check("strobe_octave", int'(octave), int'(mon_e.octave));
                check("strobe_step_idx", int'(step_idx), int'(mon_e.idx));
                if (mon_e.interval != 0)
                    check("strobe_interval", cyc - last_strobe, mon_e.interval);
                $display("strobe step=%0d keys=%03h octave=%0d at cycle %0d",
                         step_idx, keys, octave, cyc);
            end
            last_strobe = cyc;
        end
    end

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
        loop  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_keys", int'(keys), 0);
        check("rst_octave", int'(octave), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_strobe", int'(note_strobe), 0);
        check("rst_step_idx", int'(step_idx), 0);
        rst_n = 1'b1;
        record(3);
        check("idle_busy", int'(busy), 0);

        // Single pass, no loop.
        push(12'h020, 4'd5, 6'd0, 0);
        push(12'h000, 4'd5, 6'd1, 20);
        push(12'h200, 4'd5, 6'd2, 40);
        start = 1'b1;
        record(90);
        check("t1_keys_before", int'(keys_log[2]), 0);
        check("t1_keys_last_play", int'(keys_log[18]), 12'h020);
        check("t1_keys_gap", int'(keys_log[19]), 0);
        check("t1_rest_keys", int'(keys_log[40]), 0);
        check("t1_rest_octave", int'(oct_log[40]), 5);
        check("t1_e2_keys", int'(keys_log[70]), 12'h200);
        nb = 0;
        for (int k = 1; k <= 90; k++) nb += int'(busy_log[k]);
        check("t1_busy_span", nb, 82);
        check("t1_end_keys", int'(keys_log[83]), 0);
        check("t1_end_octave", int'(oct_log[83]), 0);
        check("t1_end_step_idx", int'(step_idx), 0);
        $display("pass1 done busy_cycles=%0d", nb);

        // Looping: wraps to entry 0 after END, then stop mid-rest.
        loop = 1'b1;
        push(12'h020, 4'd5, 6'd0, 0);
        push(12'h000, 4'd5, 6'd1, 20);
        push(12'h200, 4'd5, 6'd2, 40);
        push(12'h020, 4'd5, 6'd0, 22);
        push(12'h000, 4'd5, 6'd1, 20);
        start = 1'b1;
        record(110);
        nb = 0;
        for (int k = 1; k <= 110; k++) nb += int'(busy_log[k]);
        check("t2_busy_all", nb, 110);
        loop = 1'b0;
        stop = 1'b1;
        record(1);
        check("t2_stop_busy", int'(busy), 0);
        check("t2_stop_octave", int'(octave), 0);
        check("t2_stop_step_idx", int'(step_idx), 0);
        $display("loop pass stopped busy=%0d", busy);

        // Stop during PLAY of entry 2, then start+stop together.
        push(12'h020, 4'd5, 6'd0, 0);
        push(12'h000, 4'd5, 6'd1, 20);
        push(12'h200, 4'd5, 6'd2, 40);
        start = 1'b1;
        record(70);
        check("t3_keys_play", int'(keys), 12'h200);
        stop = 1'b1;
        record(1);
        check("t3_stop_keys", int'(keys), 0);
        check("t3_stop_octave", int'(octave), 0);
        check("t3_stop_busy", int'(busy), 0);
        start = 1'b1;
        stop  = 1'b1;
        record(6);
        nb = 0;
        for (int k = 1; k <= 6; k++) nb += int'(busy_log[k]);
        check("t3_start_stop_busy", nb, 0);

        // Restart while playing entry 0.
        push(12'h020, 4'd5, 6'd0, 0);
        push(12'h020, 4'd5, 6'd0, 10);
        start = 1'b1;
        record(10);
        start = 1'b1;
        record(1);
        check("t4_restart_keys", int'(keys), 0);
        check("t4_restart_busy", int'(busy), 1);
        record(5);
        stop = 1'b1;
        record(1);
        check("t4_stop_busy", int'(busy), 0);

        // Asynchronous reset mid-note.
        push(12'h020, 4'd5, 6'd0, 0);
        push(12'h000, 4'd5, 6'd1, 20);
        push(12'h200, 4'd5, 6'd2, 40);
        start = 1'b1;
        record(66);
        check("t5_pre_keys", int'(keys), 12'h200);
        check("t5_pre_step_idx", int'(step_idx), 2);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_rst_keys", int'(keys), 0);
        check("t5_rst_octave", int'(octave), 0);
        check("t5_rst_busy", int'(busy), 0);
        check("t5_rst_step_idx", int'(step_idx), 0);
        @(negedge clk);
        rst_n = 1'b1;
        record(10);
        nb = 0;
        for (int k = 1; k <= 10; k++) nb += int'(busy_log[k]);
        check("t5_post_rst_busy", nb, 0);
        check("t5_post_rst_keys", int'(keys), 0);

        check("sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
